// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - passive multiplexed 7-segment bus reader with framed valid/ready output
module seg_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     err_out
);

    // Counter is wide enough for the largest allowed STABLE_CNT.
    localparam int CW = 4;

    // Decoded tuple layout: [5:2] BCD code, [1] blank, [0] err.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] t;
        case (s)
            7'b0000001: t = {4'd0, 2'b00};
            7'b1001111: t = {4'd1, 2'b00};
            7'b0010010: t = {4'd2, 2'b00};
            7'b0000110: t = {4'd3, 2'b00};
            7'b1001100: t = {4'd4, 2'b00};
            7'b0100100: t = {4'd5, 2'b00};
            7'b0100000: t = {4'd6, 2'b00};
            7'b0001111: t = {4'd7, 2'b00};
            7'b0000000: t = {4'd8, 2'b00};
            7'b0000100: t = {4'd9, 2'b00};
            7'b1111111: t = {4'd0, 2'b10};
            default:    t = {4'd0, 2'b01};
        endcase
        return t;
    endfunction

    logic [5:0]        tuple;
    logic [DIGITS-1:0] sel;
    logic              sample_valid;
    logic [5:0]        cand  [DIGITS];
    logic [CW-1:0]     cnt   [DIGITS];
    logic [5:0]        comm  [DIGITS];
    logic [DIGITS-1:0] fresh;
    logic [DIGITS-1:0] commit;
    logic              load;

    assign tuple        = decode(seg_n);
    assign sel          = ~an_n;
    assign sample_valid = $onehot(sel);
    assign load         = (&fresh) && (!out_valid || out_ready);

    // A digit commits exactly on the clock its run of identical samples reaches STABLE_CNT.
    always_comb begin
        commit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            commit[i] = sample_valid && sel[i] && (tuple == cand[i])
                        && (cnt[i] == CW'(STABLE_CNT - 1));
        end
    end

    // Per-digit candidate tracking, saturating stability counter and committed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
                comm[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sample_valid && sel[i]) begin
                    if ((tuple == cand[i]) && (cnt[i] != '0)) begin
                        if (cnt[i] < CW'(STABLE_CNT)) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end else begin
                        cand[i] <= tuple;
                        cnt[i]  <= CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
                if (commit[i]) begin
                    comm[i] <= cand[i];
                end
            end
        end
    end

    // Frame assembly: load all committed digits once every digit is fresh; a same-cycle commit keeps its fresh flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh     <= '0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            blank_out <= '0;
            err_out   <= '0;
        end else begin
            fresh <= (load ? '0 : fresh) | commit;
            if (load) begin
                out_valid <= 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    bcd_out[4*i +: 4] <= comm[i][5:2];
                    blank_out[i]      <= comm[i][1];
                    err_out[i]        <= comm[i][0];
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - self-checking bench for seg_scan_reader
module tb_seg_scan_reader;

    localparam int D  = 4;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;

    seg_scan_reader #(.DIGITS(D), .STABLE_CNT(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .blank_out (blank_out),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a single "current run" tracker (digit, tuple, length) plus frame state.
    int          run_d;
    logic [5:0]  run_t;
    int          run_len;
    logic [5:0]  m_comm [D];
    logic [3:0]  m_fresh;
    logic        m_valid;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;

    // Frame capture while scanning.
    logic        cap_seen;
    logic [15:0] cap_bcd;
    logic [3:0]  cap_blank;
    logic [3:0]  cap_err;

    function automatic logic [6:0] glyph(input int k);
        case (k)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1111110;

    function automatic logic [5:0] ref_tuple(input logic [6:0] s);
        if (s == BLANK) return 6'b000010;
        for (int k = 0; k < 10; k++) begin
            if (glyph(k) == s) return {4'(k), 2'b00};
        end
        return 6'b000001;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        run_d   = -1;
        run_t   = '0;
        run_len = 0;
        for (int k = 0; k < D; k++) m_comm[k] = '0;
        m_fresh = '0;
        m_valid = 1'b0;
        m_bcd   = '0;
        m_blank = '0;
        m_err   = '0;
    endtask

    task automatic model_edge();
        int nsel;
        int d;
        int cd;
        logic [5:0] t;
        nsel = 0;
        d    = -1;
        cd   = -1;
        for (int k = 0; k < D; k++) begin
            if (!an_n[k]) begin
                nsel++;
                d = k;
            end
        end
        t = ref_tuple(seg_n);
        if (nsel == 1) begin
            if (d == run_d && t == run_t) begin
                run_len++;
            end else begin
                run_d   = d;
                run_t   = t;
                run_len = 1;
            end
            if (run_len == SC) cd = d;
        end else begin
            run_d = -1;
        end
        if ((&m_fresh) && (!m_valid || out_ready)) begin
            for (int k = 0; k < D; k++) begin
                m_bcd[4*k +: 4] = m_comm[k][5:2];
                m_blank[k]      = m_comm[k][1];
                m_err[k]        = m_comm[k][0];
            end
            m_valid = 1'b1;
            m_fresh = '0;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (cd >= 0) begin
            m_comm[cd]  = run_t;
            m_fresh[cd] = 1'b1;
        end
    endtask

    task automatic check_model();
        check("valid", 32'(out_valid), 32'(m_valid));
        check("bcd",   32'(bcd_out),   32'(m_bcd));
        check("blank", 32'(blank_out), 32'(m_blank));
        check("err",   32'(err_out),   32'(m_err));
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] a, input logic r);
        seg_n     = s;
        an_n      = a;
        out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        if (out_valid && out_ready) begin
            cap_seen  = 1'b1;
            cap_bcd   = bcd_out;
            cap_blank = blank_out;
            cap_err   = err_out;
        end
    endtask

    task automatic scan_digit(input int d, input logic [6:0] s, input int n, input logic r);
        for (int k = 0; k < n; k++) step(s, ~(4'b0001 << d), r);
    endtask

    task automatic scan_all(input logic [3:0][6:0] v, input int n, input logic r);
        for (int d = 0; d < D; d++) scan_digit(d, v[d], n, r);
    endtask

    task automatic hard_reset();
        rst_n     = 1'b0;
        seg_n     = BLANK;
        an_n      = 4'hf;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0][6:0] segs;
        logic [15:0]     bcd;
        logic [3:0]      blank;
        logic [3:0]      err;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [3:0] a;
        logic [6:0] base;
        logic [6:0] s;
        int len;
        int kind;

        tbl[0].segs = {glyph(4), glyph(3), glyph(2), glyph(1)};
        tbl[0].bcd = 16'h4321; tbl[0].blank = 4'b0000; tbl[0].err = 4'b0000;
        tbl[1].segs = {glyph(7), BLANK, BAD, glyph(7)};
        tbl[1].bcd = 16'h7007; tbl[1].blank = 4'b0100; tbl[1].err = 4'b0010;
        tbl[2].segs = {glyph(5), glyph(0), glyph(9), glyph(8)};
        tbl[2].bcd = 16'h5098; tbl[2].blank = 4'b0000; tbl[2].err = 4'b0000;
        tbl[3].segs = {BAD, glyph(6), BLANK, glyph(6)};
        tbl[3].bcd = 16'h0606; tbl[3].blank = 4'b0010; tbl[3].err = 4'b1000;

        hard_reset();

        // Table-driven full scans, ready held high.
        for (int v = 0; v < 4; v++) begin
            cap_seen = 1'b0;
            cap_bcd = '0; cap_blank = '0; cap_err = '0;
            scan_all(tbl[v].segs, 8, 1'b1);
            check($sformatf("tbl%0d_seen", v),  32'(cap_seen),  32'd1);
            check($sformatf("tbl%0d_bcd", v),   32'(cap_bcd),   32'(tbl[v].bcd));
            check($sformatf("tbl%0d_blank", v), 32'(cap_blank), 32'(tbl[v].blank));
            check($sformatf("tbl%0d_err", v),   32'(cap_err),   32'(tbl[v].err));
        end

        // Digit 0 glitching never commits; a steady hold then completes the frame.
        hard_reset();
        scan_digit(1, glyph(2), 8, 1'b1);
        scan_digit(2, glyph(3), 8, 1'b1);
        scan_digit(3, glyph(4), 8, 1'b1);
        for (int k = 0; k < 11; k++) scan_digit(0, (k % 2 == 0) ? glyph(0) : glyph(1), 1, 1'b1);
        check("glitch_no_frame", 32'(out_valid), 32'd0);
        scan_digit(0, glyph(1), 3, 1'b1);
        check("glitch_latency", 32'(out_valid), 32'd0);
        scan_digit(0, glyph(1), 1, 1'b1);
        check("glitch_valid", 32'(out_valid), 32'd1);
        check("glitch_bcd",   32'(bcd_out),   32'h4321);

        // Backpressure across two scans, then back-to-back load on the transfer cycle.
        hard_reset();
        scan_all({glyph(4), glyph(3), glyph(2), glyph(1)}, 8, 1'b0);
        scan_all({glyph(8), glyph(7), glyph(6), glyph(5)}, 8, 1'b0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_bcd",   32'(bcd_out),   32'h4321);
        step(BLANK, 4'hf, 1'b1);
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_bcd",   32'(bcd_out),   32'h8765);
        step(BLANK, 4'hf, 1'b1);
        check("bp_drain", 32'(out_valid), 32'd0);

        // Multi-select clears the counter mid-window.
        hard_reset();
        scan_digit(0, glyph(1), 8, 1'b1);
        scan_digit(1, glyph(2), 8, 1'b1);
        scan_digit(2, glyph(3), 8, 1'b1);
        scan_digit(3, glyph(9), 2, 1'b1);
        for (int k = 0; k < 10; k++) step(glyph(9), 4'b0011, 1'b1);
        scan_digit(3, glyph(9), 1, 1'b1);
        check("multi_cleared", 32'(out_valid), 32'd0);
        scan_digit(3, glyph(9), 2, 1'b1);
        scan_digit(3, glyph(9), 1, 1'b1);
        check("multi_valid", 32'(out_valid), 32'd1);
        check("multi_bcd",   32'(bcd_out),   32'h9321);

        // Asynchronous reset in the middle of digit 2's window.
        hard_reset();
        scan_all({glyph(4), glyph(3), glyph(2), glyph(1)}, 8, 1'b0);
        scan_digit(0, glyph(5), 8, 1'b0);
        scan_digit(1, glyph(6), 8, 1'b0);
        scan_digit(2, glyph(7), 4, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd",   32'(bcd_out),   32'd0);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        scan_digit(0, glyph(5), 8, 1'b1);
        scan_digit(1, glyph(6), 8, 1'b1);
        scan_digit(2, glyph(7), 8, 1'b1);
        check("rst_partial", 32'(out_valid), 32'd0);
        cap_seen = 1'b0;
        scan_digit(3, glyph(8), 8, 1'b1);
        check("rst_new_seen", 32'(cap_seen), 32'd1);
        check("rst_new_bcd",  32'(cap_bcd),  32'h8765);

        // Randomised windows against the reference model.
        hard_reset();
        for (int w = 0; w < 1500; w++) begin
            len  = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 4'hf;
            else if (kind == 1) a = ~(4'b0011 << $urandom_range(0, 2));
            else                a = ~(4'b0001 << $urandom_range(0, 3));
            kind = $urandom_range(0, 11);
            if (kind < 10)       base = glyph(kind);
            else if (kind == 10) base = BLANK;
            else                 base = 7'($urandom);
            for (int k = 0; k < len; k++) begin
                s = ($urandom_range(0, 7) == 0) ? glyph($urandom_range(0, 9)) : base;
                step(s, a, 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
